// File: rtl/opcode_sequencer_if.sv
// Bus bundle for opcode_sequencer: control, pattern data and sequenced outputs.
//   master : drives en/start/mode/step/dwell/data, observes opcode/index/wrap/done
//   slave  : the sequencer side (inputs and outputs reversed)
interface opcode_sequencer_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL_W  = 4
);
  localparam int unsigned IDX_W = $clog2(CHANNELS);

  logic                         en;
  logic                         start;
  logic [1:0]                   mode;
  logic [IDX_W-1:0]             step;
  logic [DWELL_W-1:0]           dwell;
  logic [CHANNELS*WIDTH-1:0]    data;
  logic [WIDTH-1:0]             opcode;
  logic [IDX_W-1:0]             index;
  logic                         wrap;
  logic                         done;

  modport master (
    output en, start, mode, step, dwell, data,
    input  opcode, index, wrap, done
  );

  modport slave (
    input  en, start, mode, step, dwell, data,
    output opcode, index, wrap, done
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Channel sequencer for effect patterns: steps an index through CHANNELS
// opcode slots with programmable stride, dwell and traversal mode.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   seq_bus    : slave side of opcode_sequencer_if
//                in : en, start, mode, step, dwell, data
//                out: opcode (combinational slot[index]), index, wrap, done (registered)
module opcode_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  opcode_sequencer_if.slave    seq_bus
);

  localparam int unsigned IDX_W = $clog2(CHANNELS);
  // One extra bit so index+stride never overflows for non-power-of-two CHANNELS.
  localparam int unsigned AW    = IDX_W + 1;

  localparam logic [AW-1:0] CH    = AW'(CHANNELS);
  localparam logic [AW-1:0] CH_M1 = AW'(CHANNELS - 1);
  localparam logic [AW-1:0] CH_M2 = AW'(CHANNELS - 2);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [IDX_W-1:0]   index_q, index_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic [AW-1:0]      idx_x;
  logic [AW-1:0]      stride;
  logic [AW-1:0]      sum_x;
  logic [WIDTH-1:0]   opcode_c;

  // Next-state: start overrides en; dwell countdown gates every advance.
  always_comb begin
    index_d = index_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = done_q;
    wrap_d  = 1'b0;

    idx_x  = {1'b0, index_q};
    stride = ({1'b0, seq_bus.step} > CH_M1) ? CH_M1 : {1'b0, seq_bus.step};
    sum_x  = idx_x + stride;

    if (seq_bus.start) begin
      index_d = '0;
      cnt_d   = '0;
      dir_d   = DIR_UP;
      done_d  = 1'b0;
    end else if (seq_bus.en) begin
      // Leaving one-shot after completion releases the sticky done.
      if (seq_bus.mode != MODE_ONE && done_q) begin
        done_d = 1'b0;
      end

      if (seq_bus.mode == MODE_ONE && done_q) begin
        // Completed one-shot: everything frozen until start.
      end else if (cnt_q < seq_bus.dwell) begin
        cnt_d = cnt_q + DWELL_W'(1);
      end else begin
        cnt_d = '0;
        case (seq_bus.mode)
          MODE_UP: begin
            if (sum_x >= CH) begin
              index_d = IDX_W'(sum_x - CH);
              wrap_d  = 1'b1;
            end else begin
              index_d = IDX_W'(sum_x);
            end
          end
          MODE_DOWN: begin
            if (stride > idx_x) begin
              index_d = IDX_W'(idx_x + CH - stride);
              wrap_d  = 1'b1;
            end else begin
              index_d = IDX_W'(idx_x - stride);
            end
          end
          MODE_PING: begin
            if (dir_q == DIR_UP) begin
              if (idx_x == CH_M1) begin
                index_d = IDX_W'(CH_M2);
                dir_d   = DIR_DOWN;
                wrap_d  = 1'b1;
              end else begin
                index_d = IDX_W'(idx_x + AW'(1));
              end
            end else begin
              if (idx_x == '0) begin
                index_d = IDX_W'(1);
                dir_d   = DIR_UP;
                wrap_d  = 1'b1;
              end else begin
                index_d = IDX_W'(idx_x - AW'(1));
              end
            end
          end
          default: begin
            // One-shot: a stride past the last slot finishes in place.
            if (sum_x > CH_M1) begin
              done_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              index_d = IDX_W'(sum_x);
            end
          end
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Slot select from live data; zero latency from data to opcode.
  always_comb begin
    opcode_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (index_q == IDX_W'(k)) begin
        opcode_c = seq_bus.data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign seq_bus.opcode = opcode_c;
  assign seq_bus.index  = index_q;
  assign seq_bus.wrap   = wrap_q;
  assign seq_bus.done   = done_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer (CHANNELS=4, WIDTH=4, data=16'h0F5A).
// Each clocked step pushes its expected outputs into a scoreboard queue before
// the edge; the entry is popped and compared once the DUT has updated.
module tb_opcode_sequencer;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DWELL_W  = 4;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] op;
    logic       wrap;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  logic [15:0] data_v;

  opcode_sequencer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL_W(DWELL_W)) bus ();

  opcode_sequencer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seq_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] slot(input logic [1:0] i);
    logic [15:0] d;
    d = data_v;
    return d[i*4 +: 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge with its expected result queued before the edge.
  task automatic cyc(input string tag, input logic [1:0] ei, input logic ew, input logic ed);
    exp_t e;
    e.idx  = ei;
    e.op   = slot(ei);
    e.wrap = ew;
    e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_idx"},  32'(bus.index),  32'(e.idx));
      chk({tag, "_op"},   32'(bus.opcode), 32'(e.op));
      chk({tag, "_wrap"}, 32'(bus.wrap),   32'(e.wrap));
      chk({tag, "_done"}, 32'(bus.done),   32'(e.done));
    end
  endtask

  task automatic restart();
    bus.start = 1'b1;
    cyc("start", 2'd0, 1'b0, 1'b0);
    bus.start = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    data_v    = 16'h0F5A;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.step  = 2'd1;
    bus.dwell = 4'd0;
    bus.data  = data_v;

    // Reset state
    #2;
    chk("rst_idx",  32'(bus.index),  32'd0);
    chk("rst_op",   32'(bus.opcode), 32'hA);
    chk("rst_wrap", 32'(bus.wrap),   32'd0);
    chk("rst_done", 32'(bus.done),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Wrap-up, stride 1, no dwell
    bus.en = 1'b1;
    cyc("up1", 2'd1, 1'b0, 1'b0);
    cyc("up1", 2'd2, 1'b0, 1'b0);
    cyc("up1", 2'd3, 1'b0, 1'b0);
    cyc("up1", 2'd0, 1'b1, 1'b0);
    cyc("up1", 2'd1, 1'b0, 1'b0);
    restart();

    // Wrap-up, stride 3, dwell 2: advance every third edge
    bus.step  = 2'd3;
    bus.dwell = 4'd2;
    cyc("up3", 2'd0, 1'b0, 1'b0);
    cyc("up3", 2'd0, 1'b0, 1'b0);
    cyc("up3", 2'd3, 1'b0, 1'b0);
    cyc("up3", 2'd3, 1'b0, 1'b0);
    cyc("up3", 2'd3, 1'b0, 1'b0);
    cyc("up3", 2'd2, 1'b1, 1'b0);
    cyc("up3", 2'd2, 1'b0, 1'b0);
    cyc("up3", 2'd2, 1'b0, 1'b0);
    cyc("up3", 2'd1, 1'b1, 1'b0);
    cyc("up3", 2'd1, 1'b0, 1'b0);
    cyc("up3", 2'd1, 1'b0, 1'b0);
    cyc("up3", 2'd0, 1'b1, 1'b0);

    // Wrap-down, stride 1, then stride 0 holds
    bus.mode  = 2'b01;
    bus.step  = 2'd1;
    bus.dwell = 4'd0;
    cyc("dn1", 2'd3, 1'b1, 1'b0);
    cyc("dn1", 2'd2, 1'b0, 1'b0);
    bus.step = 2'd0;
    cyc("dn0", 2'd2, 1'b0, 1'b0);
    cyc("dn0", 2'd2, 1'b0, 1'b0);
    restart();

    // Ping-pong
    bus.mode = 2'b10;
    bus.step = 2'd3;
    cyc("pp", 2'd1, 1'b0, 1'b0);
    cyc("pp", 2'd2, 1'b0, 1'b0);
    cyc("pp", 2'd3, 1'b0, 1'b0);
    cyc("pp", 2'd2, 1'b1, 1'b0);
    cyc("pp", 2'd1, 1'b0, 1'b0);
    cyc("pp", 2'd0, 1'b0, 1'b0);
    cyc("pp", 2'd1, 1'b1, 1'b0);
    restart();

    // One-shot, stride 2: finish at slot 2, then frozen until start
    bus.mode = 2'b11;
    bus.step = 2'd2;
    cyc("one", 2'd2, 1'b0, 1'b0);
    cyc("one", 2'd2, 1'b1, 1'b1);
    cyc("one", 2'd2, 1'b0, 1'b1);
    cyc("one", 2'd2, 1'b0, 1'b1);
    restart();

    // Enable dropped mid-dwell freezes the countdown
    bus.mode  = 2'b00;
    bus.step  = 2'd1;
    bus.dwell = 4'd3;
    cyc("en", 2'd0, 1'b0, 1'b0);
    cyc("en", 2'd0, 1'b0, 1'b0);
    bus.en = 1'b0;
    cyc("en_off", 2'd0, 1'b0, 1'b0);
    cyc("en_off", 2'd0, 1'b0, 1'b0);
    cyc("en_off", 2'd0, 1'b0, 1'b0);
    bus.en = 1'b1;
    cyc("en", 2'd0, 1'b0, 1'b0);
    cyc("en", 2'd1, 1'b0, 1'b0);

    // Live data change reaches opcode without a clock
    bus.data = 16'hFFFF;
    #1;
    chk("data_live", 32'(bus.opcode), 32'hF);
    bus.data = data_v;
    #1;
    chk("data_back", 32'(bus.opcode), 32'h5);
    restart();

    // Asynchronous reset mid-bounce (index 2, heading down)
    bus.mode  = 2'b10;
    bus.dwell = 4'd0;
    cyc("ppr", 2'd1, 1'b0, 1'b0);
    cyc("ppr", 2'd2, 1'b0, 1'b0);
    cyc("ppr", 2'd3, 1'b0, 1'b0);
    cyc("ppr", 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_idx",  32'(bus.index),  32'd0);
    chk("arst_op",   32'(bus.opcode), 32'hA);
    chk("arst_wrap", 32'(bus.wrap),   32'd0);
    #2;
    rst_n = 1'b1;
    // Direction restored to up: 0 -> 1 without a reversal pulse
    cyc("post_rst", 2'd1, 1'b0, 1'b0);
    cyc("post_rst", 2'd2, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
